lsu_dbus: RTL
=============

Name: lsu_dbus

Overview:
- Load/store unit directly downstream of the instruction decoder/controller in the execute/memory stage.
- Consumes the decoder's `rd_en`, `wr_en` and `mem_mode`, the ALU-computed address and the rs2 store data.
- Performs the data-memory access over a valid/ready request / rvalid response bus, then returns the aligned, sign- or zero-extended load data.
- Stalls the pipeline until the access completes and reports misaligned, illegal-mode and timeout faults.

Parameters:
- ADDR_W, 32, data bus address width.
- TIMEOUT_CYCLES, 16, bus cycles allowed from request issue to completion before a fault is raised (≥2).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- rd_en  input  1  decoder: load in current instruction
- wr_en  input  1  decoder: store in current instruction
- mem_mode  input  3  000 B, 001 H, 010 W, 011 BU, 100 HU; others illegal
- addr  input  ADDR_W  effective address from ALU
- wdata  input  32  store data (rs2)
- flush  input  1  squash the current instruction
- stall  output  1  hold the pipeline
- load_data  output  32  extended load result
- load_valid  output  1  one-cycle pulse, load_data valid
- misalign_exc  output  1  one-cycle pulse
- fault_exc  output  1  one-cycle pulse: illegal mode or timeout
- fault_addr  output  ADDR_W  address of the faulting access
- dbus_valid  output  1  request valid
- dbus_ready  input  1  request accepted
- dbus_we  output  1  write request
- dbus_addr  output  ADDR_W  word-aligned address, {addr[31:2],2'b00}
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  lane-replicated store data
- dbus_rvalid  input  1  read response valid
- dbus_rdata  input  32  read response data

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - State IDLE.
  - All outputs 0: `stall`, `load_valid`, `misalign_exc`, `fault_exc`, `dbus_valid`, `dbus_we`, `dbus_be`, `dbus_addr`, `dbus_wdata`, `load_data`, `fault_addr`.
  - Timeout counter 0.
- Reset mid-operation: return to IDLE and drop `dbus_valid` on the next edge. Any outstanding response is ignored.
- `op = (rd_en | wr_en) & ~flush`.
- Stall: `stall = op & (state != DONE)`. This is combinational, so the pipeline advances only in the DONE cycle.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, with `op` true:
  - Illegal case (mode ∈ {101,110,111}, or `rd_en & wr_en`, or store with mode 011/100) → DONE with `fault_exc` set.
  - Misaligned case (H/HU with addr[0]=1, W with addr[1:0]≠0) → DONE with `misalign_exc` set.
  - Neither → latch `addr`, `be`, `wdata`, `we` and mode; go to REQ. `dbus_valid` goes high in the cycle after the instruction appears.
- REQ:
  - `dbus_valid`=1 and the bus outputs are held stable until `dbus_ready`.
  - `dbus_ready` with a store → DONE.
  - `dbus_ready` with a load → WAIT_RSP.
  - `flush` before acceptance → drop `dbus_valid`, go to IDLE, no pulse.
- WAIT_RSP:
  - `dbus_rvalid` → capture extended data into `load_data`, go to DONE.
  - `flush` here does not cancel; the response is awaited and then discarded (no `load_valid`).
- DONE: lasts exactly one cycle with `stall`=0.
  - `load_valid`=1 for a successful load.
  - Exception pulses as latched; `fault_addr` = latched addr.
  - Always → IDLE.
- Timeout: a counter clears on entering REQ and increments in REQ/WAIT_RSP. When it reaches TIMEOUT_CYCLES:
  - Drop `dbus_valid`.
  - Go to DONE with `fault_exc`.
  - Ignore a late `dbus_rvalid`.
- `dbus_rvalid` arriving in the same cycle as `dbus_ready` is not legal on this bus; `dbus_rvalid` is honoured only in WAIT_RSP.
- Store lanes:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - SW: `be = 1111`.
- Loads: `be` as for stores of the same size. The byte is `rdata[8*addr[1:0] +: 8]` and the half is `rdata[16*addr[1] +: 16]`. B/H sign-extend; BU/HU zero-extend.
- Minimum latency:
  - Store: 3 cycles including the DONE cycle, with `dbus_ready` same-cycle.
  - Load: 4 cycles, with `dbus_rvalid` one cycle after accept.

Decomposition:
- `lsu_pkg`:
  - `mem_mode_e` (MM_B, MM_H, MM_W, MM_BU, MM_HU, MM_NONE=3'b111).
  - `lsu_state_e`.
  - Helper functions `is_misaligned()` and `is_legal_mode()`.
- One sub-module, `lsu_align`, purely combinational:
  - Store direction: `be` and `dbus_wdata` generation.
  - Load direction: lane extraction and extension.
  - Reused by the FSM top `lsu_dbus`.

Test Plan:
- Byte load, addr 0x1003, mode 000, rdata 0x80AABBCC → `load_data` 0xFFFFFF80, `load_valid` 1 cycle; `dbus_addr` 0x1000, `be` 1000; stall high 3 cycles.
- Unsigned half load, addr 0x2002, mode 100, rdata 0xF00D1234 → `load_data` 0x0000F00D.
- Half store, addr 0x3002, mode 001, `wdata` 0xDEADBEEF → `dbus_we` 1, `be` 1100, `dbus_wdata` 0xBEEFBEEF. With `dbus_ready` delayed 5 cycles, request outputs are stable throughout and no `load_valid` is produced.
- Word load, addr 0x4001 → `misalign_exc` pulse, `fault_addr` 0x4001, no `dbus_valid`. Load with mode 110 → `fault_exc`, no bus access.
- `dbus_ready` never asserted with TIMEOUT_CYCLES=16 → `fault_exc` 16 cycles after REQ entry, then `dbus_valid` 0. A late `dbus_rvalid` is ignored.
- Flush during REQ → back to IDLE, no pulses. Flush during WAIT_RSP → response consumed, no `load_valid`. `rst_n` low in WAIT_RSP → all outputs 0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        MM_B    = 3'b000,
        MM_H    = 3'b001,
        MM_W    = 3'b010,
        MM_BU   = 3'b011,
        MM_HU   = 3'b100,
        MM_NONE = 3'b111
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } lsu_state_e;

    // Unsigned modes only exist for loads; a single instruction cannot both load and store.
    function automatic logic is_legal_mode(input logic [2:0] mode, input logic rd, input logic wr);
        logic legal;
        legal = (mode <= 3'b100) && !(rd && wr)
                && !(wr && (mode == 3'b011 || mode == 3'b100));
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
        logic mis;
        case (mem_mode_e'(mode))
            MM_H, MM_HU: mis = addr_lo[0];
            MM_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rdata[8*addr_lo +: 8];
        half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be          = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        case (mem_mode_e'(mode))
            MM_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{byte_sel[7]}}, byte_sel};
            end
            MM_BU: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {24'd0, byte_sel};
            end
            MM_H: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{half_sel[15]}}, half_sel};
            end
            MM_HU: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {16'd0, half_sel};
            end
            MM_W: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dbus.sv
// Load/store unit FSM: issues one data-bus access per instruction and stalls until it completes.
module lsu_dbus
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        mem_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_exc,
    output logic              fault_exc,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              dbus_valid,
    input  logic              dbus_ready,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        state;
    logic [2:0]        mode_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              squashed;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              op;
    logic [2:0]        align_mode;
    logic [1:0]        align_lo;
    logic [3:0]        be;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rdata_ext;
    logic              last_cycle;
    logic              expired;

    assign op    = (rd_en | wr_en) & ~flush;
    assign stall = op & (state != ST_DONE);

    // Live inputs drive the lane logic at issue; afterwards the latched access does.
    assign align_mode = (state == ST_IDLE) ? mem_mode : mode_reg;
    assign align_lo   = (state == ST_IDLE) ? addr[1:0] : addr_reg[1:0];

    // last_cycle: final cycle in which completion is still allowed; expired: already past it.
    assign last_cycle = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign expired    = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES));

    lsu_align u_align (
        .mode        (align_mode),
        .addr_lo     (align_lo),
        .wdata       (wdata),
        .rdata       (dbus_rdata),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mode_reg     <= 3'b000;
            addr_reg     <= '0;
            squashed     <= 1'b0;
            tmo_cnt      <= '0;
            load_data    <= 32'd0;
            load_valid   <= 1'b0;
            misalign_exc <= 1'b0;
            fault_exc    <= 1'b0;
            fault_addr   <= '0;
            dbus_valid   <= 1'b0;
            dbus_we      <= 1'b0;
            dbus_addr    <= '0;
            dbus_be      <= 4'b0000;
            dbus_wdata   <= 32'd0;
        end else begin
            load_valid   <= 1'b0;
            misalign_exc <= 1'b0;
            fault_exc    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op) begin
                        if (!is_legal_mode(mem_mode, rd_en, wr_en)) begin
                            fault_exc  <= 1'b1;
                            fault_addr <= addr;
                            state      <= ST_DONE;
                        end else if (is_misaligned(mem_mode, addr[1:0])) begin
                            misalign_exc <= 1'b1;
                            fault_addr   <= addr;
                            state        <= ST_DONE;
                        end else begin
                            addr_reg   <= addr;
                            mode_reg   <= mem_mode;
                            dbus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dbus_be    <= be;
                            dbus_wdata <= wdata_lanes;
                            dbus_we    <= wr_en;
                            dbus_valid <= 1'b1;
                            squashed   <= 1'b0;
                            tmo_cnt    <= '0;
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dbus_ready) begin
                        dbus_valid <= 1'b0;
                        squashed   <= flush;
                        tmo_cnt    <= tmo_cnt + 1'b1;
                        state      <= dbus_we ? ST_DONE : ST_WAIT_RSP;
                    end else if (flush) begin
                        dbus_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (last_cycle) begin
                        dbus_valid <= 1'b0;
                        fault_exc  <= 1'b1;
                        fault_addr <= addr_reg;
                        state      <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    // A squashed load still drains its response, but reports nothing.
                    if (dbus_rvalid && !expired) begin
                        if (squashed || flush) begin
                            state <= ST_IDLE;
                        end else begin
                            load_data  <= rdata_ext;
                            load_valid <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else if (last_cycle) begin
                        if (squashed || flush) begin
                            state <= ST_IDLE;
                        end else begin
                            fault_exc  <= 1'b1;
                            fault_addr <= addr_reg;
                            state      <= ST_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (flush) begin
                            squashed <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
